adder_result_tx: RTL and testbench
==================================

# adder_result_tx

Byte-serial transmitter for the three-operand adder's results. It captures one result set (x, y, z, f), frames it with a header byte, and streams it one byte per beat over a valid/ready interface. It sits between the adder core and the 8-bit dedicated output pins, so the results can be read off-chip over a single byte lane.

## Interface
- `WIDTH`, 8: width of each result word and of the output byte lane.
- `HEADER`, 8'hA5: first byte of every frame.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_valid` input 1: a result set is presented on x/y/z/f.
- `load_ready` output 1: the block can accept a result set.
- `x`, `y`, `z`, `f` input WIDTH each: adder results, sampled on load handshake.
- `tx_data` output WIDTH: current frame byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: downstream accepts the byte.
- `tx_last` output 1: current byte is the final byte of the frame.
- `busy` output 1: a frame is in progress (state is not IDLE).

## Operation
- FSM states:
  - IDLE: `load_ready` = 1, `tx_valid` = 0.
  - HDR: sends `HEADER`.
  - DATA: sends x, y, z, f in that order; a 2-bit index selects the word.
  - CSUM: sends the checksum; exists only with the macro.
- Load: when `load_valid` & `load_ready`, register x/y/z/f and go IDLE→HDR. `load_valid` outside IDLE is ignored and leaves no side effects.
- Beat: a byte transfers when `tx_valid` & `tx_ready`.
  - HDR→DATA with index 0.
  - DATA advances the index on each transfer.
  - After f (index 3): go to CSUM, or to IDLE when the macro is absent.
  - CSUM→IDLE on transfer.
- Backpressure: while `tx_ready` = 0, `tx_data`, `tx_valid` and `tx_last` hold stable. A byte is never dropped or repeated.
- `tx_last` is 1 only on the final byte (f, or the checksum when the macro is defined).
- Captured registers do not change mid-frame.
- `busy` = (state != IDLE).
- All outputs come directly from registers or the state decode; there is no combinational path from `tx_ready` to `tx_data`.

## Timing
- Reset values: state IDLE, `load_ready` = 1, `tx_valid` = 0, `tx_last` = 0, `tx_data` = 0, `busy` = 0, captured words = 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). The partial frame is not resumed.
- Latency:
  - Load handshake at edge N gives the header on `tx_data` with `tx_valid` = 1 after edge N.
  - With `tx_ready` held high, one byte transfers per cycle. A frame takes 5 cycles, or 6 with the macro.
- Turnaround: after the last byte transfers, the block is in IDLE for at least one cycle (`load_ready` = 1) before the next header. Minimum frame period is 6 cycles, or 7 with the macro.
- `load_ready` is low from the cycle after the load handshake until the cycle after the last transfer.

## Configuration
- Macro: `ADDER_RESULT_TX_CHECKSUM_EN`.
- Defined:
  - A sixth byte is appended: x ^ y ^ z ^ f, computed from the captured words. The header is excluded.
  - `tx_last` is on the checksum byte.
- Undefined:
  - The CSUM state and the XOR logic are absent.
  - The frame is 5 bytes and `tx_last` is on f.

## Structure
- Shared package `adder_tx_pkg` holds:
  - the state enum (IDLE, HDR, DATA, CSUM);
  - the default header constant 8'hA5;
  - frame-length constants `FRAME_LEN_BASE` = 5 and `FRAME_LEN_CSUM` = 6.
- One sub-module, `adder_tx_csum`: a WIDTH-generic 4-input XOR reducer, instantiated only under the macro.
- Everything else is one flat FSM module.

## Test plan
- Basic frame:
  - Stimulus: load x=01, y=02, z=04, f=08 with `tx_ready` high throughout.
  - Required response: bytes A5, 01, 02, 04, 08 on consecutive cycles, plus 0F under the macro. `tx_last` is 1 only on the final byte. `load_ready` returns to 1 one cycle after the last transfer.
- Backpressure:
  - Stimulus: same load; drop `tx_ready` for 3 cycles while byte 02 is presented.
  - Required response: `tx_data` = 02 and `tx_valid` = 1 are held for all 3 cycles, then the stream resumes without loss or duplication.
- Load while busy:
  - Stimulus: during the frame, pulse `load_valid` with x=FF, y=FF, z=FF, f=FF.
  - Required response: it is ignored; the frame continues with the original values; `load_ready` stays 0.
- Reset mid-frame:
  - Stimulus: assert `rst_n` = 0 asynchronously while byte 04 is presented.
  - Required response: `tx_valid`, `tx_last` and `busy` go to 0 and `load_ready` to 1 immediately. After release, a new load x=10, y=20, z=30, f=40 produces A5, 10, 20, 30, 40 (checksum 40 under the macro).
- Back-to-back:
  - Stimulus: `load_valid` held high with two result sets, AA/55/AA/55 then 00/00/00/FF.
  - Required response: two complete frames separated by exactly one idle cycle. Under the macro the checksums are 00 and FF.

Source files
------------

// File: rtl/adder_tx_pkg.sv
// rtl/adder_tx_pkg.sv - shared states and constants for the adder result transmitter
package adder_tx_pkg;

    // Frame sequencer states; CSUM is only reachable when the checksum byte is built in
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } tx_state_t;

    // First byte of every frame unless the top is given another header
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Bytes per frame: header + x, y, z, f, optionally followed by the XOR checksum
    localparam int FRAME_LEN_BASE = 5;
    localparam int FRAME_LEN_CSUM = 6;

    // Index of the final result word (f) inside the DATA state
    localparam logic [1:0] LAST_WORD_IDX = 2'd3;

endpackage

// File: rtl/adder_tx_csum.sv
// rtl/adder_tx_csum.sv - WIDTH-generic 4-input XOR reducer for the frame checksum
module adder_tx_csum #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum
);

    // Pure reduction; the inputs are the held capture registers, so the result is stable all frame
    assign sum = a ^ b ^ c ^ d;

endmodule

// File: rtl/adder_result_tx.sv
// rtl/adder_result_tx.sv - byte-serial framer for x/y/z/f results (optional checksum: ADDER_RESULT_TX_CHECKSUM_EN)
module adder_result_tx
    import adder_tx_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] HEADER = WIDTH'(DEFAULT_HEADER)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy
);

    tx_state_t        state;
    logic [1:0]       word_idx;
    logic [1:0]       next_idx;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic [WIDTH-1:0] next_word;
    logic             load_fire;
    logic             tx_fire;

`ifdef ADDER_RESULT_TX_CHECKSUM_EN
    logic [WIDTH-1:0] csum;

    adder_tx_csum #(
        .WIDTH (WIDTH)
    ) u_csum (
        .a   (x_q),
        .b   (y_q),
        .c   (z_q),
        .d   (f_q),
        .sum (csum)
    );
`endif

    // Handshake and status outputs are pure state decode, so tx_ready never reaches tx_data
    assign load_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign tx_valid   = (state != ST_IDLE);
    assign tx_data    = data_q;
    assign tx_last    = last_q;

    assign load_fire  = load_valid && load_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign next_idx   = word_idx + 2'd1;

    // Select the captured word that follows the one currently on the lane
    always_comb begin
        next_word = x_q;
        case (next_idx)
            2'd0:    next_word = x_q;
            2'd1:    next_word = y_q;
            2'd2:    next_word = z_q;
            default: next_word = f_q;
        endcase
    end

    // Capture registers only load in IDLE, so a frame always streams one consistent result set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
            f_q <= '0;
        end else if (load_fire) begin
            x_q <= x;
            y_q <= y;
            z_q <= z;
            f_q <= f;
        end
    end

    // Frame sequencer: the byte for the next beat is registered on each transfer, holding under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_idx <= 2'd0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_fire) begin
                        state  <= ST_HDR;
                        data_q <= HEADER;
                        last_q <= 1'b0;
                    end
                end

                ST_HDR: begin
                    if (tx_fire) begin
                        state    <= ST_DATA;
                        word_idx <= 2'd0;
                        // x is taken from the live register: it was captured a cycle earlier
                        data_q   <= x_q;
                        last_q   <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (tx_fire) begin
                        if (word_idx == LAST_WORD_IDX) begin
                            word_idx <= 2'd0;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                            state    <= ST_CSUM;
                            data_q   <= csum;
                            last_q   <= 1'b1;
`else
                            state    <= ST_IDLE;
                            data_q   <= '0;
                            last_q   <= 1'b0;
`endif
                        end else begin
                            word_idx <= next_idx;
                            data_q   <= next_word;
`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                            last_q   <= 1'b0;
`else
                            // Without the checksum, f is the final byte of the frame
                            last_q   <= (next_idx == LAST_WORD_IDX);
`endif
                        end
                    end
                end

`ifdef ADDER_RESULT_TX_CHECKSUM_EN
                ST_CSUM: begin
                    if (tx_fire) begin
                        state  <= ST_IDLE;
                        data_q <= '0;
                        last_q <= 1'b0;
                    end
                end
`endif

                default: begin
                    state    <= ST_IDLE;
                    word_idx <= 2'd0;
                    data_q   <= '0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_tx.sv
// tb/tb_adder_result_tx.sv - scoreboard bench for adder_result_tx (honours ADDER_RESULT_TX_CHECKSUM_EN)
`timescale 1ns/1ps
module tb_adder_result_tx;

`ifdef ADDER_RESULT_TX_CHECKSUM_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;
    logic [7:0] z = 8'h00;
    logic [7:0] f = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       busy;

    logic       rnd_mode = 1'b0;
    logic       rnd_bit = 1'b1;
    logic       man_ready = 1'b1;

    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [8:0] exp_q[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    assign tx_ready = rnd_mode ? rnd_bit : man_ready;

    adder_result_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .x          (x),
        .y          (y),
        .z          (z),
        .f          (f),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference frame: header, the four words, optional XOR of the words; last flag on the final byte
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        logic [7:0] bytes[6];
        bytes[0] = 8'hA5;
        bytes[1] = a;
        bytes[2] = b;
        bytes[3] = c;
        bytes[4] = d;
        bytes[5] = a ^ b ^ c ^ d;
        for (int i = 0; i < FLEN; i++) exp_q.push_back({(i == FLEN - 1), bytes[i]});
    endtask

    // Monitor: every transferred byte must match the scoreboard head; stalled beats must hold
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {tx_last, tx_data}, 9'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("byte", {tx_last, tx_data}, e);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    // Called and returns at posedge+1; holds load_valid until accepted, optionally leaves it high
    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                           input bit keep);
        bit done;
        done = 1'b0;
        load_valid = 1'b1;
        x = a; y = b; z = c; f = d;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (load_ready) begin
                push_frame(a, b, c, d);
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!keep) load_valid = 1'b0;
        if (!done) check("load_timeout", 0, 1);
    endtask

    task automatic wait_frame_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (tx_valid && tx_ready && tx_last) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        check({name, "_ready_after"}, {load_ready, busy}, 2'b10);
    endtask

    task automatic wait_data(input logic [7:0] v);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clk); #1;
            if (tx_valid && tx_data == v) seen = 1'b1;
        end
        if (!seen) check("wait_data_timeout", 0, 1);
    endtask

    initial begin
        int a0, a1;
        #1;
        check("reset_outputs", {load_ready, tx_valid, tx_last, busy, tx_data}, {4'b1000, 8'h00});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        do_load(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);
        check("hdr_after_load", {tx_valid, tx_data, load_ready}, {1'b1, 8'hA5, 1'b0});
        wait_frame_end("basic");

        // Backpressure on byte 02
        do_load(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);
        wait_data(8'h02);
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held", {tx_valid, tx_data}, {1'b1, 8'h02});
        end
        @(posedge clk); #1;
        man_ready = 1'b1;
        wait_frame_end("bp");

        // Load while busy is ignored
        do_load(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);
        @(posedge clk); #1;
        load_valid = 1'b1;
        x = 8'hFF; y = 8'hFF; z = 8'hFF; f = 8'hFF;
        @(negedge clk);
        check("busy_load_ready", {load_ready, busy}, 2'b01);
        @(posedge clk); #1;
        load_valid = 1'b0;
        wait_frame_end("busy_load");

        // Asynchronous reset mid-frame
        do_load(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);
        wait_data(8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {tx_valid, tx_last, busy, load_ready, tx_data}, {4'b0001, 8'h00});
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load(8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
        wait_frame_end("post_reset");

        // Back-to-back with load_valid held
        do_load(8'hAA, 8'h55, 8'hAA, 8'h55, 1'b1);
        a0 = acc_cyc;
        do_load(8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
        a1 = acc_cyc;
        check("b2b_period", a1 - a0, FLEN + 1);
        wait_frame_end("b2b");

        // Randomised frames with random backpressure and idle gaps
        rnd_mode = 1'b1;
        for (int k = 0; k < 25; k++) begin
            do_load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
        @(posedge clk); #1;
        rnd_mode = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 check("final_idle", {load_ready, busy, tx_valid}, 3'b100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
